// File: rtl/mc_control.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and writeback
// for a small MIPS-like subset, and counts retired instructions.
module mc_control #(
    parameter int ALU_OP_W = 4,
    parameter bit EN_NOR   = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                alu_zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                alu_src_b,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_we,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [5:0] INST_FUNC = 6'h00;
    localparam logic [5:0] INST_J    = 6'h02;
    localparam logic [5:0] INST_BEQ  = 6'h04;
    localparam logic [5:0] INST_ORI  = 6'h0D;
    localparam logic [5:0] INST_LUI  = 6'h0F;
    localparam logic [5:0] INST_LW   = 6'h23;
    localparam logic [5:0] INST_NOR  = 6'h27;
    localparam logic [5:0] INST_SW   = 6'h2B;
    localparam logic [5:0] FUNC_ADD  = 6'h20;

    localparam logic [2:0] ALU_NULL = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_NOR  = 3'd4;
    localparam logic [2:0] ALU_LUI  = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        K_ADD, K_NOR, K_LUI, K_ORI, K_LW, K_SW, K_BEQ, K_J
    } kind_e;

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    kind_e            dec_kind;
    logic             dec_legal;

    logic             mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;
    logic             alu_src_b_c, reg_dst_c, mem_to_reg_c;
    logic [1:0]       pc_src_c;
    logic [2:0]       alu_code;

    always_comb begin
        dec_kind  = K_ADD;
        dec_legal = 1'b1;
        case (opcode)
            INST_FUNC: begin
                dec_kind  = K_ADD;
                dec_legal = (func == FUNC_ADD);
            end
            INST_LUI: dec_kind = K_LUI;
            INST_ORI: dec_kind = K_ORI;
            INST_LW:  dec_kind = K_LW;
            INST_SW:  dec_kind = K_SW;
            INST_BEQ: dec_kind = K_BEQ;
            INST_J:   dec_kind = K_J;
            INST_NOR: begin
                dec_kind  = K_NOR;
                dec_legal = EN_NOR;
            end
            default:  dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        retired_d    = retired_q;
        illegal_d    = illegal_q;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'd0;
        alu_src_b_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_we_c     = 1'b0;
        alu_code     = ALU_NULL;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ack) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            // The instruction kind is captured here so later opcode/func changes are ignored.
            S_DECODE: begin
                if (dec_legal) begin
                    kind_d  = dec_kind;
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_ADD: begin alu_code = ALU_ADD; state_d = S_WB; end
                    K_NOR: begin alu_code = ALU_NOR; state_d = S_WB; end
                    K_LUI: begin alu_code = ALU_LUI; alu_src_b_c = 1'b1; state_d = S_WB; end
                    K_ORI: begin alu_code = ALU_OR;  alu_src_b_c = 1'b1; state_d = S_WB; end
                    K_LW, K_SW: begin
                        alu_code    = ALU_ADD;
                        alu_src_b_c = 1'b1;
                        state_d     = S_MEM;
                    end
                    K_BEQ: begin
                        alu_code = ALU_SUB;
                        if (alu_zero) begin
                            pc_we_c  = 1'b1;
                            pc_src_c = 2'd1;
                        end
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                    default: begin
                        pc_we_c   = 1'b1;
                        pc_src_c  = 2'd2;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (kind_q == K_SW);
                if (mem_ack) begin
                    if (kind_q == K_SW) begin
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_c     = 1'b1;
                reg_dst_c    = (kind_q == K_ADD) || (kind_q == K_NOR);
                mem_to_reg_c = (kind_q == K_LW);
                retired_d    = retired_q + CNT_W'(1);
                state_d      = S_FETCH;
            end
            S_TRAP: illegal_d = 1'b1;
            default: begin
                illegal_d = 1'b1;
                state_d   = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            kind_q    <= K_ADD;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are gated by rst_n so they drop the instant reset asserts, even though
    // the reset state (FETCH) would otherwise request memory.
    assign mem_req    = mem_req_c    & rst_n;
    assign mem_we     = mem_we_c     & rst_n;
    assign ir_we      = ir_we_c      & rst_n;
    assign pc_we      = pc_we_c      & rst_n;
    assign reg_we     = reg_we_c     & rst_n;
    assign alu_src_b  = alu_src_b_c  & rst_n;
    assign reg_dst    = reg_dst_c    & rst_n;
    assign mem_to_reg = mem_to_reg_c & rst_n;
    assign pc_src     = rst_n ? pc_src_c : 2'd0;
    assign alu_op     = rst_n ? ALU_OP_W'(alu_code) : '0;
    assign illegal    = illegal_q;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: default build plus EN_NOR=0 and CNT_W=4 builds
// driven from the same stimulus.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ack = 1'b0;

    logic       mem_req, mem_we, ir_we, pc_we, alu_src_b, reg_dst, mem_to_reg, reg_we, illegal;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic [2:0] state;
    logic [31:0] retired;

    logic       mem_req_n, mem_we_n, ir_we_n, pc_we_n, alu_src_b_n, reg_dst_n, mem_to_reg_n, reg_we_n, illegal_n;
    logic [1:0] pc_src_n;
    logic [3:0] alu_op_n;
    logic [2:0] state_n;
    logic [31:0] retired_n;

    logic       mem_req_c, mem_we_c, ir_we_c, pc_we_c, alu_src_b_c, reg_dst_c, mem_to_reg_c, reg_we_c, illegal_c;
    logic [1:0] pc_src_c;
    logic [3:0] alu_op_c;
    logic [2:0] state_c;
    logic [3:0] retired_c;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .reg_we(reg_we), .illegal(illegal), .state(state), .retired(retired)
    );

    mc_control #(.EN_NOR(1'b0)) dut_nn (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req_n), .mem_we(mem_we_n), .ir_we(ir_we_n), .pc_we(pc_we_n),
        .pc_src(pc_src_n), .alu_src_b(alu_src_b_n), .reg_dst(reg_dst_n), .mem_to_reg(mem_to_reg_n),
        .alu_op(alu_op_n), .reg_we(reg_we_n), .illegal(illegal_n), .state(state_n), .retired(retired_n)
    );

    mc_control #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req_c), .mem_we(mem_we_c), .ir_we(ir_we_c), .pc_we(pc_we_c),
        .pc_src(pc_src_c), .alu_src_b(alu_src_b_c), .reg_dst(reg_dst_c), .mem_to_reg(mem_to_reg_c),
        .alu_op(alu_op_c), .reg_we(reg_we_c), .illegal(illegal_c), .state(state_c), .retired(retired_c)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        mem_ack = 0; alu_zero = 0; opcode = 0; func = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #2;
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        chk("rel_mem_req", mem_req, 1);
    endtask

    // FETCH with nwait un-acked cycles before the acking one.
    task automatic fetch(input int nwait);
        for (int i = 0; i < nwait; i++) begin
            mem_ack = 0; #1;
            chk("f_wait_state", state, 0);
            chk("f_wait_req", mem_req, 1);
            chk("f_wait_irwe", ir_we, 0);
            tick();
        end
        mem_ack = 1; #1;
        chk("f_req", mem_req, 1);
        chk("f_we", {mem_we, ir_we, pc_we}, 3'b011);
        chk("f_pcsrc", pc_src, 0);
        chk("f_aluop", alu_op, 0);
        tick();
        mem_ack = 0;
    endtask

    task automatic run_j();
        fetch(0);
        opcode = 6'h02; #1;
        chk("j_dec", state, 1);
        tick();
        chk("j_exec", {pc_we, pc_src}, 3'b110);
        tick();
    endtask

    initial begin
        logic [31:0] r0;
        int c0;

        // async reset, no clock edge needed
        #2 rst_n = 0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_retired", retired, 0);
        chk("ar_illegal", illegal, 0);
        chk("ar_strobes", {mem_req, mem_we, ir_we, pc_we, reg_we}, 0);
        chk("ar_aluop", alu_op, 0);
        chk("ar_pcsrc", pc_src, 0);
        do_reset();

        // ADD, zero-wait; opcode changes after DECODE must not matter
        fetch(0);
        opcode = 6'h00; func = 6'h20; mem_ack = 1; #1;
        chk("add_dec", state, 1);
        tick();
        opcode = 6'h3F; func = 6'h00; #1;
        chk("add_exec", state, 2);
        chk("add_aluop", alu_op, 1);
        chk("add_srcb", alu_src_b, 0);
        chk("add_noreq", mem_req, 0);
        tick();
        mem_ack = 0; #1;
        chk("add_wb", state, 4);
        chk("add_wb_we", {reg_we, reg_dst, mem_to_reg}, 3'b110);
        chk("add_aluop_wb", alu_op, 0);
        chk("add_ret0", retired, 0);
        tick();
        chk("add_fetch", state, 0);
        chk("add_ret1", retired, 1);

        // LW: FETCH ack after 2 waits, MEM ack after 1 wait -> 8 cycles
        c0 = cyc;
        fetch(2);
        opcode = 6'h23; #1;
        chk("lw_dec", state, 1);
        tick();
        opcode = 6'h00;
        #1;
        chk("lw_exec", {alu_op, alu_src_b}, {4'd1, 1'b1});
        tick();
        chk("lw_mem_wait", {state, mem_req, mem_we}, {3'd3, 1'b1, 1'b0});
        tick();
        mem_ack = 1; #1;
        chk("lw_mem_ack", {state, mem_req, mem_we}, {3'd3, 1'b1, 1'b0});
        tick();
        mem_ack = 0; #1;
        chk("lw_wb", {state, reg_we, reg_dst, mem_to_reg}, {3'd4, 3'b101});
        tick();
        chk("lw_cycles", cyc - c0, 8);
        chk("lw_ret", retired, 2);

        // BEQ taken / not taken
        for (int z = 1; z >= 0; z--) begin
            r0 = retired;
            fetch(0);
            opcode = 6'h04; #1;
            tick();
            alu_zero = z[0]; #1;
            chk("beq_aluop", alu_op, 2);
            chk("beq_pcwe", pc_we, z[0]);
            chk("beq_pcsrc", pc_src, z[0] ? 2'd1 : 2'd0);
            tick();
            alu_zero = 0;
            chk("beq_fetch", state, 0);
            chk("beq_ret", retired, r0 + 1);
        end

        // SW with ack held through DECODE/EXEC (ignored there), zero-wait MEM
        r0 = retired;
        fetch(0);
        opcode = 6'h2B; mem_ack = 1; #1;
        tick();
        chk("sw_exec", state, 2);
        chk("sw_exec_req", mem_req, 0);
        tick();
        chk("sw_mem", {state, mem_req, mem_we, reg_we}, {3'd3, 3'b110});
        tick();
        mem_ack = 0;
        chk("sw_fetch", state, 0);
        chk("sw_ret", retired, r0 + 1);

        // NOR: default build executes, EN_NOR=0 build traps
        fetch(0);
        opcode = 6'h27; #1;
        tick();
        chk("nor_exec", {state, alu_op}, {3'd2, 4'd4});
        chk("nn_trap", {state_n, illegal_n}, {3'd7, 1'b1});
        tick();
        chk("nor_wb", {reg_we, reg_dst}, 2'b11);
        tick();

        // illegal opcode -> TRAP forever, ack ignored
        do_reset();
        fetch(0);
        opcode = 6'h3F; #1;
        chk("ill_dec", illegal, 0);
        tick();
        opcode = 6'h00; func = 6'h20;
        for (int i = 0; i < 20; i++) begin
            mem_ack = i[0]; #1;
            chk("trap_hold", {state, illegal, mem_req, ir_we, pc_we, reg_we}, {3'd7, 5'b10000});
            chk("trap_ret", retired, 0);
            tick();
        end
        mem_ack = 0;
        // ADD with bad func is illegal too
        do_reset();
        fetch(0);
        opcode = 6'h00; func = 6'h21; #1;
        tick();
        chk("badfunc", {state, illegal}, {3'd7, 1'b1});

        // 17 J: 4-bit counter wraps to 1
        do_reset();
        for (int i = 0; i < 17; i++) run_j();
        chk("j_ret32", retired, 17);
        chk("j_ret4", retired_c, 1);

        // reset in the middle of SW MEM wait
        fetch(0);
        opcode = 6'h2B; #1;
        tick();
        tick();
        chk("swr_mem", {state, mem_req, mem_we}, {3'd3, 2'b11});
        #2 rst_n = 0;
        #1;
        chk("swr_drop", {mem_req, mem_we, reg_we}, 0);
        chk("swr_state", state, 0);
        chk("swr_ret", retired, 0);
        mem_ack = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        rst_n = 1; #1;
        chk("swr_refetch", {state, mem_req, mem_we}, {3'd0, 2'b10});
        tick();
        chk("swr_noret", retired, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
